// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the default operand width.
package muldiv_unit_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit_sign_fixup.sv
// Sign handling around the unsigned divider core: operand magnitudes on the
// way in, quotient/remainder negation on the way out.
module sign_fixup #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] abs_a,
  output logic [WIDTH-1:0] abs_b,
  input  logic             neg_quo,
  input  logic             neg_rem,
  input  logic [WIDTH-1:0] quo_mag,
  input  logic [WIDTH-1:0] rem_mag,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  // The most-negative value maps onto itself, which the unsigned core
  // still reads correctly as 2**(WIDTH-1).
  assign abs_a = in_a[WIDTH-1] ? -in_a : in_a;
  assign abs_b = in_b[WIDTH-1] ? -in_b : in_b;

  assign quo = neg_quo ? -quo_mag : quo_mag;
  assign rem = neg_rem ? -rem_mag : rem_mag;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring) sharing one
// 2*WIDTH accumulator; WIDTH iterations per operation, one-cycle done pulse.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         op_code,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               qm1_q, qm1_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               is_div_q, is_div_d;
  logic               b_neg_q, b_neg_d;
  logic               b_zero_q, b_zero_d;

  logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
  logic [WIDTH:0]     booth_hi, booth_m, booth_sum;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic               accept;

  sign_fixup #(.WIDTH(WIDTH)) u_sign_fixup (
    .in_a    (in_a),
    .in_b    (in_b),
    .abs_a   (abs_a),
    .abs_b   (abs_b),
    .neg_quo (a_q[WIDTH-1] ^ b_neg_q),
    .neg_rem (a_q[WIDTH-1]),
    .quo_mag (acc_q[WIDTH-1:0]),
    .rem_mag (acc_q[2*WIDTH-1:WIDTH]),
    .quo     (quo_fix),
    .rem     (rem_fix)
  );

  // Booth step: add/subtract the multiplicand into the sign-extended high
  // half, then shift the whole {acc, q_-1} pair right arithmetically.
  always_comb begin
    booth_hi = {acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]};
    booth_m  = {opnd_q[WIDTH-1], opnd_q};
    unique case ({acc_q[0], qm1_q})
      2'b01:   booth_sum = booth_hi + booth_m;
      2'b10:   booth_sum = booth_hi - booth_m;
      default: booth_sum = booth_hi;
    endcase
    mul_next = {booth_sum, acc_q[WIDTH-1:1]};
  end

  // Restoring step on magnitudes: the partial remainder stays below the
  // divisor, so bit WIDTH of the difference is a clean borrow flag.
  always_comb begin
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd_q};
    if (!rem_diff[WIDTH]) div_next = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else                  div_next = {acc_q[2*WIDTH-2:0], 1'b0};
  end

  assign accept = start && ((op_code == OP_MUL) || (op_code == OP_DIV));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = (state_q == ST_RUN);
    done_d   = (state_q == ST_DONE);
    dbz_d    = 1'b0;
    acc_d    = acc_q;
    qm1_d    = qm1_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    b_neg_d  = b_neg_q;
    b_zero_d = b_zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          a_d      = in_a;
          is_div_d = (op_code == OP_DIV);
          b_neg_d  = in_b[WIDTH-1];
          b_zero_d = (in_b == '0);
          qm1_d    = 1'b0;
          if (op_code == OP_DIV) begin
            acc_d  = {{WIDTH{1'b0}}, abs_a};
            opnd_d = abs_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, in_b};
            opnd_d = in_a;
          end
        end
      end
      ST_RUN: begin
        if (is_div_q) begin
          acc_d = div_next;
        end else begin
          acc_d = mul_next;
          qm1_d = acc_q[0];
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!is_div_q)     result_d = acc_q;
        else if (b_zero_q) result_d = {a_q, {WIDTH{1'b1}}};
        else               result_d = {rem_fix, quo_fix};
        dbz_d = is_div_q && b_zero_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on the
  // accepting edge before anything reads them.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    qm1_q    <= qm1_d;
    opnd_q   <= opnd_d;
    a_q      <= a_d;
    is_div_q <= is_div_d;
    b_neg_q  <= b_neg_d;
    b_zero_q <= b_zero_d;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign result      = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised self-check of muldiv_unit against a scoreboard of
// expected results computed with native 64-bit signed arithmetic.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           clear;
  logic           start;
  logic [4:0]     op_code;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [2*W-1:0] result;

  logic [63:0] exp_res_q[$];
  logic        exp_dbz_q[$];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .op_code     (op_code),
    .in_a        (in_a),
    .in_b        (in_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_MUL) return 64'(sa * sb);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // One operation: push expectation, pulse start, then watch the DUT until done.
  // With poke set, a second start is driven during RUN and must be ignored.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [63:0] exp, input logic exp_dbz,
                        input bit poke);
    int          cyc, busy_cyc, stray;
    logic [63:0] e;
    logic        ed;
    @(negedge clk);
    op_code = op; in_a = a; in_b = b; start = 1'b1;
    exp_res_q.push_back(exp);
    exp_dbz_q.push_back(exp_dbz);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; busy_cyc = 0; stray = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) busy_cyc++;
      if (div_by_zero !== 1'b0) stray++;
      if (poke && cyc == 5) begin
        op_code = OP_DIV; in_a = 32'd999; in_b = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e  = exp_res_q.pop_front();
    ed = exp_dbz_q.pop_front();
    check({tag, "_latency"}, 64'(cyc), 64'(W + 1));
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(W));
    check({tag, "_result"}, result, e);
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(ed));
    check({tag, "_dbz_outside_done"}, 64'(stray), 64'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check({tag, "_dbz_after_done"}, 64'(div_by_zero), 64'd0);
    check({tag, "_result_hold"}, result, e);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [4:0]   rop;
    int           idle_busy, idle_done, got_done;

    clear = 1'b1; start = 1'b0; op_code = '0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    check("reset_result", result, 64'd0);

    // start together with clear must not be accepted
    start = 1'b1; op_code = OP_MUL; in_a = 32'd3; in_b = 32'd4;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    check("clear_prio_busy", 64'(busy), 64'd0);

    run_op("mul_10x10", OP_MUL, 32'd10, 32'd10, 64'd100, 1'b0, 1'b0);
    run_op("mul_m7x6", OP_MUL, 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0, 1'b0);
    run_op("mul_minxmin", OP_MUL, 32'h8000_0000, 32'h8000_0000,
           64'h4000_0000_0000_0000, 1'b0, 1'b0);
    run_op("div_m17d5", OP_DIV, 32'hFFFF_FFEF, 32'd5, 64'hFFFF_FFFE_FFFF_FFFD, 1'b0, 1'b0);
    run_op("div_mind_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h0000_0000_8000_0000, 1'b0, 1'b0);
    run_op("div_25d0", OP_DIV, 32'd25, 32'd0, 64'h0000_0019_FFFF_FFFF, 1'b1, 1'b0);
    run_op("div_100d7", OP_DIV, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 1'b0);

    // unsupported op code: no start, outputs unchanged
    @(negedge clk);
    op_code = 5'b00101; in_a = 32'd5; in_b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_busy = 0; idle_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b0) idle_busy++;
      if (done !== 1'b0) idle_done++;
      @(negedge clk);
    end
    check("badop_busy", 64'(idle_busy), 64'd0);
    check("badop_done", 64'(idle_done), 64'd0);
    check("badop_result", result, 64'h0000_0002_0000_000E);

    run_op("mul_restart_ignored", OP_MUL, 32'd123, 32'hFFFF_FFD3,
           64'hFFFF_FFFF_FFFF_EA61, 1'b0, 1'b1);

    // clear at iteration 10 of a MUL aborts it
    @(negedge clk);
    op_code = OP_MUL; in_a = 32'd77; in_b = 32'd88; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_done", 64'(done), 64'd0);
    got_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done !== 1'b0) got_done++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(got_done), 64'd0);

    for (int n = 0; n < 6; n++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = (n % 2 == 0) ? OP_MUL : OP_DIV;
      if (n == 5) rb = 32'd0;
      run_op($sformatf("rand%0d", n), rop, ra, rb, model(rop, ra, rb),
             (rop == OP_DIV) && (rb == 32'd0), 1'b0);
    end

    check("scoreboard_empty", 64'(exp_res_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
